// File: rtl/dense_mult_pkg.sv
// Shared types and helpers for the dense_mult sequencer.
// Optional build macro used by dense_mult_seq: DENSE_MULT_SEQ_PERF_EN.
package dense_mult_pkg;

  localparam int N_DEF            = 3;
  localparam int LANES_DEF        = N_DEF + 2;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int OUTPUT_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef logic [DATA_WIDTH_DEF-1:0]   operand_t;
  typedef logic [OUTPUT_WIDTH_DEF-1:0] result_t;

  // Index width for a table of 'depth' entries, never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dense_mult_seq_if.sv
// Array-side bus between the sequencer and one dense_mult instance.
// Handshake: every lane word is qualified by its own valid bit and is
// consumed in the cycle it is presented; there is no ready/back-pressure,
// so neither side may stall the other.
interface dense_mult_seq_if #(
  parameter int LANES        = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int OUTPUT_WIDTH = 16
);
  logic [LANES*DATA_WIDTH-1:0]   a_out_bus;
  logic [LANES-1:0]              valid_a_out;
  logic [LANES*DATA_WIDTH-1:0]   b_out_bus;
  logic [LANES-1:0]              valid_b_out;
  logic [LANES*OUTPUT_WIDTH-1:0] s_in_bus;
  logic [LANES-1:0]              valid_s_in;

  // Sequencer side
  modport master (
    output a_out_bus, valid_a_out, b_out_bus, valid_b_out,
    input  s_in_bus, valid_s_in
  );

  // Array side
  modport slave (
    input  a_out_bus, valid_a_out, b_out_bus, valid_b_out,
    output s_in_bus, valid_s_in
  );
endinterface

// File: rtl/lane_skew_rd.sv
// One operand lane: K_LEN-deep buffer read out with a fixed per-lane skew.
// Lane LANE_IDX presents beat t-LANE_IDX while that falls inside the lane.
module lane_skew_rd
  import dense_mult_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int K_LEN      = 8,
  parameter  int LANE_IDX   = 0,
  parameter  int TW         = 4,
  localparam int IW         = idx_w(K_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  feed_en,
  input  logic [TW-1:0]         t,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] mem_q [K_LEN];
  logic [TW-1:0]         k_off;
  logic                  in_win;
  logic [DATA_WIDTH-1:0] data_d, data_q;
  logic                  valid_d, valid_q;

  // Operand storage; not reset, contents survive a run and a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Skewed read: beat k = t - LANE_IDX is live while 0 <= k < K_LEN.
  always_comb begin
    k_off   = t - TW'(LANE_IDX);
    in_win  = feed_en && (t >= TW'(LANE_IDX)) && (k_off < TW'(K_LEN));
    data_d  = '0;
    valid_d = 1'b0;
    if (in_win) begin
      data_d  = mem_q[k_off[IW-1:0]];
      valid_d = 1'b1;
    end
  end

  // Registered lane output; reset drops valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dense_mult_seq.sv
// Sequencer for a dense_mult systolic array: loads operand lanes, feeds them
// skewed into the array, captures valid-tagged results, signals completion.
// Optional build macro: DENSE_MULT_SEQ_PERF_EN enables the cycle_cnt counter.
module dense_mult_seq
  import dense_mult_pkg::*;
#(
  parameter  int N            = 3,
  parameter  int DATA_WIDTH   = 8,
  parameter  int OUTPUT_WIDTH = 16,
  parameter  int K_LEN        = 8,
  parameter  int DRAIN_MAX    = 24,
  localparam int LANES        = N + 2,
  localparam int LW           = idx_w(LANES),
  localparam int IW           = idx_w(K_LEN),
  localparam int CW           = $clog2(K_LEN + 1),
  localparam int FEED_LEN     = K_LEN + LANES - 1,
  localparam int TW           = idx_w(FEED_LEN),
  localparam int DRW          = $clog2(DRAIN_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [LW-1:0]           ld_lane,
  input  logic [IW-1:0]           ld_idx,
  input  logic [DATA_WIDTH-1:0]   ld_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_ovf,
  dense_mult_seq_if.master        arr,
  input  logic [LW-1:0]           rd_lane,
  input  logic [IW-1:0]           rd_idx,
  output logic [OUTPUT_WIDTH-1:0] rd_data,
  output logic [LANES*CW-1:0]     res_cnt,
  output logic [15:0]             cycle_cnt,
  output state_t                  dbg_state
);

  state_t                  state_q, state_d;
  logic [TW-1:0]           t_q, t_d;
  logic [DRW-1:0]          drain_q, drain_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    to_q, to_d, ovf_q, ovf_d;
  logic [CW-1:0]           res_cnt_q [LANES];
  logic [CW-1:0]           res_cnt_d [LANES];
  logic [OUTPUT_WIDTH-1:0] res_q [LANES][K_LEN];
  logic [OUTPUT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [LANES-1:0]        cap_we;
  logic                    all_full, capturing, ld_ok, feed_en;
  logic [DATA_WIDTH-1:0]   a_data [LANES];
  logic [DATA_WIDTH-1:0]   b_data [LANES];
  logic [LANES-1:0]        a_vld, b_vld;

  assign ld_ok   = ld_en && (state_q == S_IDLE);
  assign feed_en = (state_q == S_FEED);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_skew_rd #(.DATA_WIDTH(DATA_WIDTH), .K_LEN(K_LEN), .LANE_IDX(i), .TW(TW)) u_a (
      .clk(clk), .rst_n(rst_n),
      .wr_en(ld_ok && !ld_sel && (ld_lane == LW'(i))), .wr_idx(ld_idx), .wr_data(ld_data),
      .feed_en(feed_en), .t(t_q), .data_o(a_data[i]), .valid_o(a_vld[i])
    );
    lane_skew_rd #(.DATA_WIDTH(DATA_WIDTH), .K_LEN(K_LEN), .LANE_IDX(i), .TW(TW)) u_b (
      .clk(clk), .rst_n(rst_n),
      .wr_en(ld_ok && ld_sel && (ld_lane == LW'(i))), .wr_idx(ld_idx), .wr_data(ld_data),
      .feed_en(feed_en), .t(t_q), .data_o(b_data[i]), .valid_o(b_vld[i])
    );
  end

  // Flatten lane outputs onto the array bus and counts onto res_cnt.
  always_comb begin
    arr.a_out_bus   = '0;
    arr.b_out_bus   = '0;
    arr.valid_a_out = a_vld;
    arr.valid_b_out = b_vld;
    res_cnt         = '0;
    for (int i = 0; i < LANES; i++) begin
      arr.a_out_bus[i*DATA_WIDTH +: DATA_WIDTH] = a_data[i];
      arr.b_out_bus[i*DATA_WIDTH +: DATA_WIDTH] = b_data[i];
      res_cnt[i*CW +: CW]                       = res_cnt_q[i];
    end
  end

  // Next-state, feed/drain counters, capture bookkeeping and error flags.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    drain_d   = drain_q;
    to_d      = to_q;
    ovf_d     = ovf_q;
    res_cnt_d = res_cnt_q;
    cap_we    = '0;
    all_full  = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      if (res_cnt_q[j] != CW'(K_LEN)) all_full = 1'b0;
    end
    capturing = (state_q == S_FEED) || (state_q == S_DRAIN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          t_d     = '0;
          to_d    = 1'b0;
          ovf_d   = 1'b0;
          for (int j = 0; j < LANES; j++) res_cnt_d[j] = '0;
        end
      end
      S_FEED: begin
        if (t_q == TW'(FEED_LEN - 1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q + DRW'(1);
        if (all_full) begin
          state_d = S_DONE;
        end else if (drain_d == DRW'(DRAIN_MAX)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A full lane drops further results and flags the overflow.
    if (capturing) begin
      for (int j = 0; j < LANES; j++) begin
        if (arr.valid_s_in[j]) begin
          if (res_cnt_q[j] != CW'(K_LEN)) begin
            cap_we[j]    = 1'b1;
            res_cnt_d[j] = res_cnt_q[j] + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
    end
    busy_d = (state_d == S_FEED) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Result read port: out-of-range lanes return zero.
  always_comb begin
    rd_data_d = '0;
    if ({1'b0, rd_lane} < (LW+1)'(LANES)) rd_data_d = res_q[rd_lane][rd_idx];
  end

  // FSM and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      for (int j = 0; j < LANES; j++) res_cnt_q[j] <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      for (int j = 0; j < LANES; j++) res_cnt_q[j] <= res_cnt_d[j];
    end
  end

  // Result buffer; not reset so partial results remain readable.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (cap_we[j]) res_q[j][res_cnt_q[j][IW-1:0]] <= arr.s_in_bus[j*OUTPUT_WIDTH +: OUTPUT_WIDTH];
    end
  end

`ifdef DENSE_MULT_SEQ_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  // Run length from FEED entry through DONE, held until the next start.
  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == S_IDLE) && start) cyc_d = '0;
    else if ((state_q != S_IDLE) && (cyc_q != 16'hFFFF)) cyc_d = cyc_q + 16'd1;
  end

  // Run-length register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = to_q;
  assign err_ovf     = ovf_q;
  assign rd_data     = rd_data_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_dense_mult_seq.sv
// Bench for dense_mult_seq: scenario table plus randomized runs, with the
// array side played by a simple result generator and a reference model.
module tb_dense_mult_seq;
  import dense_mult_pkg::*;

  localparam int N         = 3;
  localparam int LANES     = N + 2;
  localparam int DW        = 8;
  localparam int OW        = 16;
  localparam int K_LEN     = 8;
  localparam int DRAIN_MAX = 24;
  localparam int FEED_LEN  = K_LEN + LANES - 1;
  localparam int LW        = 3;
  localparam int IW        = 3;
  localparam int CW        = 4;
  localparam int NSCEN     = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst_n, ld_en, ld_sel, start;
  logic [LW-1:0] ld_lane, rd_lane;
  logic [IW-1:0] ld_idx, rd_idx;
  logic [DW-1:0] ld_data;
  logic busy, done, err_timeout, err_ovf;
  logic [OW-1:0] rd_data;
  logic [LANES*CW-1:0] res_cnt;
  logic [15:0] cycle_cnt;
  state_t dbg_state;

  dense_mult_seq_if #(.LANES(LANES), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW)) arr_if ();

  dense_mult_seq #(.N(N), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .K_LEN(K_LEN), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_sel(ld_sel), .ld_lane(ld_lane),
    .ld_idx(ld_idx), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_ovf(err_ovf), .arr(arr_if), .rd_lane(rd_lane),
    .rd_idx(rd_idx), .rd_data(rd_data), .res_cnt(res_cnt), .cycle_cnt(cycle_cnt),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [OW-1:0] exp_q[$];
  logic [DW-1:0] a_m [LANES][K_LEN];
  logic [DW-1:0] b_m [LANES][K_LEN];
  logic [OW-1:0] m_res [LANES][K_LEN];
  int            m_cnt [LANES];

  typedef struct {
    bit                     pattern;
    bit                     poke;
    logic [LANES-1:0][3:0]  n_send;
    bit                     exp_to;
    bit                     exp_ovf;
  } scen_t;
  scen_t tbl [NSCEN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_scen(input int s, input bit pat, input bit poke, input int n0, input int n1,
                          input int n2, input int n3, input int n4, input bit to, input bit ovf);
    tbl[s].pattern   = pat;
    tbl[s].poke      = poke;
    tbl[s].n_send[0] = 4'(n0);
    tbl[s].n_send[1] = 4'(n1);
    tbl[s].n_send[2] = 4'(n2);
    tbl[s].n_send[3] = 4'(n3);
    tbl[s].n_send[4] = 4'(n4);
    tbl[s].exp_to    = to;
    tbl[s].exp_ovf   = ovf;
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_ops(input bit pat);
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < K_LEN; k++) begin
          logic [DW-1:0] v;
          v = pat ? DW'(8*i + k + (sel != 0 ? 'h40 : 0)) : DW'($urandom);
          if (sel != 0) b_m[i][k] = v;
          else          a_m[i][k] = v;
          ld_en = 1'b1; ld_sel = (sel != 0); ld_lane = LW'(i); ld_idx = IW'(k); ld_data = v;
          @(negedge clk);
        end
      end
    end
    ld_en = 1'b0;
  endtask

  task automatic check_feed(input int c);
    logic [LANES*DW-1:0] ea, eb;
    logic [LANES-1:0]    eva, evb;
    int kk;
    ea = '0; eb = '0; eva = '0; evb = '0;
    for (int i = 0; i < LANES; i++) begin
      kk = c - 1 - i;
      if (kk >= 0 && kk < K_LEN) begin
        ea[i*DW +: DW] = a_m[i][kk];
        eb[i*DW +: DW] = b_m[i][kk];
        eva[i] = 1'b1;
        evb[i] = 1'b1;
      end
    end
    check($sformatf("a_bus c%0d", c), arr_if.a_out_bus, ea);
    check($sformatf("b_bus c%0d", c), arr_if.b_out_bus, eb);
    check($sformatf("valid_a c%0d", c), arr_if.valid_a_out, eva);
    check($sformatf("valid_b c%0d", c), arr_if.valid_b_out, evb);
  endtask

  function automatic logic [LANES*CW-1:0] exp_cnt_vec();
    logic [LANES*CW-1:0] v;
    v = '0;
    for (int j = 0; j < LANES; j++) v[j*CW +: CW] = CW'(m_cnt[j]);
    return v;
  endfunction

  task automatic readback(input int lane, input int n);
    for (int k = 0; k < n; k++) begin
      rd_lane = LW'(lane); rd_idx = IW'(k);
      exp_q.push_back(m_res[lane][k]);
      @(negedge clk);
      check($sformatf("rd_data[%0d][%0d]", lane, k), rd_data, exp_q.pop_front());
    end
  endtask

  task automatic run_scen(input int s);
    int  c, done_c, sent [LANES];
    bit  fin, full, v;
    logic [OW-1:0] d;
    load_ops(tbl[s].pattern);
    for (int j = 0; j < LANES; j++) begin m_cnt[j] = 0; sent[j] = 0; end
    done_c = -1; fin = 1'b0; c = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && c < FEED_LEN + DRAIN_MAX + 4) begin
      check_feed(c);
      check($sformatf("busy s%0d c%0d", s, c), busy, (c != done_c));
      check($sformatf("done s%0d c%0d", s, c), done, (c == done_c));
      if (c == 0) begin
        check($sformatf("start_clr_to s%0d", s), err_timeout, 1'b0);
        check($sformatf("start_clr_ovf s%0d", s), err_ovf, 1'b0);
        check($sformatf("start_clr_cnt s%0d", s), res_cnt, '0);
      end
      if (c == done_c) begin
        fin = 1'b1;
      end else begin
        if (c >= FEED_LEN && done_c < 0) begin
          full = 1'b1;
          for (int j = 0; j < LANES; j++) if (m_cnt[j] != K_LEN) full = 1'b0;
          if (full || (c - FEED_LEN == DRAIN_MAX - 1)) done_c = c + 1;
        end
        if (tbl[s].poke) begin
          if (c == 4) begin
            ld_en = 1'b1; ld_sel = 1'b0; ld_lane = '0; ld_idx = IW'(K_LEN - 1); ld_data = ~a_m[0][K_LEN-1];
          end
          if (c == 5) begin ld_en = 1'b0; start = 1'b1; end
          if (c == 6) start = 1'b0;
        end
        for (int j = 0; j < LANES; j++) begin
          v = 1'b0;
          if (sent[j] < int'(tbl[s].n_send[j])) v = (tbl[s].n_send[j] > K_LEN) ? 1'b1 : ($urandom_range(0, 3) != 0);
          d = OW'($urandom);
          if (v) begin
            sent[j]++;
            if (m_cnt[j] < K_LEN) begin m_res[j][m_cnt[j]] = d; m_cnt[j]++; end
          end
          arr_if.valid_s_in[j] = v;
          arr_if.s_in_bus[j*OW +: OW] = d;
        end
        @(negedge clk);
        c++;
      end
    end
    if (!fin) check($sformatf("done_reached s%0d", s), 1'b0, 1'b1);
    arr_if.valid_s_in = '0;
    @(negedge clk);
    check($sformatf("idle_busy s%0d", s), busy, 1'b0);
    check($sformatf("idle_done s%0d", s), done, 1'b0);
    check($sformatf("idle_state s%0d", s), dbg_state, S_IDLE);
    check($sformatf("err_timeout s%0d", s), err_timeout, tbl[s].exp_to);
    check($sformatf("err_ovf s%0d", s), err_ovf, tbl[s].exp_ovf);
    check($sformatf("res_cnt s%0d", s), res_cnt, exp_cnt_vec());
`ifdef DENSE_MULT_SEQ_PERF_EN
    check($sformatf("cycle_cnt s%0d", s), cycle_cnt, 64'(done_c + 1));
`else
    check($sformatf("cycle_cnt s%0d", s), cycle_cnt, 64'd0);
`endif
    for (int j = 0; j < LANES; j++) readback(j, m_cnt[j]);
  endtask

  // Reset asserted in the middle of FEED after a few results were captured.
  task automatic reset_mid_feed();
    load_ops(1'b0);
    for (int j = 0; j < LANES; j++) m_cnt[j] = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      arr_if.valid_s_in = '0;
      if (c < 3) begin
        m_res[1][c] = OW'($urandom);
        arr_if.valid_s_in[1] = 1'b1;
        arr_if.s_in_bus[OW +: OW] = m_res[1][c];
      end
      @(negedge clk);
    end
    arr_if.valid_s_in = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid valid_a", arr_if.valid_a_out, '0);
    check("rst_mid valid_b", arr_if.valid_b_out, '0);
    check("rst_mid busy", busy, 1'b0);
    check("rst_mid state", dbg_state, S_IDLE);
    check("rst_mid res_cnt", res_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    readback(1, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_lane = '0; ld_idx = '0; ld_data = '0;
    start = 1'b0; rd_lane = '0; rd_idx = '0;
    arr_if.s_in_bus = '0; arr_if.valid_s_in = '0;

    //        s  pat poke  n0 n1 n2 n3 n4  to ovf
    set_scen(0, 1,  1,    8, 8, 8, 8, 8,  0, 0);
    set_scen(1, 0,  0,    8, 8, 8, 0, 8,  1, 0);
    set_scen(2, 0,  0,    9, 8, 8, 8, 8,  0, 1);
    set_scen(3, 0,  0,    8, 8, 8, 8, 8,  0, 0);
    set_scen(4, 0,  0,    8, 5, 8, 8, 0,  1, 0);
    for (int s = 5; s < NSCEN; s++) begin
      int n [LANES];
      bit to, ovf;
      to = 1'b0; ovf = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        int r;
        r = $urandom_range(0, 9);
        n[j] = (r < 6) ? K_LEN : (r == 6) ? K_LEN + 1 : $urandom_range(0, K_LEN - 1);
        if (n[j] < K_LEN) to = 1'b1;
        if (n[j] > K_LEN) ovf = 1'b1;
      end
      set_scen(s, 0, 0, n[0], n[1], n[2], n[3], n[4], to, ovf);
    end

    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err_timeout", err_timeout, 1'b0);
    check("reset err_ovf", err_ovf, 1'b0);
    check("reset valid_a", arr_if.valid_a_out, '0);
    check("reset a_bus", arr_if.a_out_bus, '0);
    check("reset valid_b", arr_if.valid_b_out, '0);
    check("reset res_cnt", res_cnt, '0);
    check("reset rd_data", rd_data, '0);
    check("reset cycle_cnt", cycle_cnt, '0);
    check("reset state", dbg_state, S_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < NSCEN; s++) run_scen(s);
    reset_mid_feed();
    run_scen(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dense_mult_seq.md
Name: dense_mult_seq

Overview:
Sequencer for the dense_mult systolic array. It holds operand lanes loaded over a simple write port and streams them into the array's a/b lanes with per-lane skew and valid bits. It then captures the array's valid-tagged s outputs into a result buffer and signals completion. It sits between the host/register interface and dense_mult, with one instance per array.

Parameters:
N, 3, array grid size; LANES = N+2 is a derived localparam (lane count of dense_mult).
DATA_WIDTH, 8, operand width.
OUTPUT_WIDTH, 16, result width.
K_LEN, 8, beats per operand lane and results expected per output lane.
DRAIN_MAX, 24, maximum drain cycles before timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ld_en  in  1  operand write strobe
ld_sel  in  1  0 = A buffer, 1 = B buffer
ld_lane  in  $clog2(LANES)  lane index
ld_idx  in  $clog2(K_LEN)  beat index
ld_data  in  DATA_WIDTH  operand value
start  in  1  run request, single-cycle pulse
busy  out  1  high from FEED through DRAIN
done  out  1  one-cycle completion pulse
err_timeout  out  1  sticky; cleared on accepted start
err_ovf  out  1  sticky; result overflow on any lane; cleared on accepted start
a_out_bus  out  LANES x DATA_WIDTH  to dense_mult a_in_bus
valid_a_out  out  LANES  to valid_bit_a_in
b_out_bus  out  LANES x DATA_WIDTH  to b_in_bus
valid_b_out  out  LANES  to valid_bit_b_in
s_in_bus  in  LANES x OUTPUT_WIDTH  from s_out_bus
valid_s_in  in  LANES  from valid_bit_s_out
rd_lane  in  $clog2(LANES)  result read lane
rd_idx  in  $clog2(K_LEN)  result read index
rd_data  out  OUTPUT_WIDTH  result read data, registered, 1-cycle latency
res_cnt  out  LANES x $clog2(K_LEN+1)  results captured per lane
cycle_cnt  out  16  run length (see Optional Feature)

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; pointers and counters 0; error flags 0. Operand and result memories are not reset.
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE -> FEED on start.
  - FEED -> DRAIN after FEED_LEN = K_LEN+LANES-1 cycles.
  - DRAIN -> DONE when every res_cnt equals K_LEN, or when the drain counter reaches DRAIN_MAX (then set err_timeout).
  - DONE -> IDLE unconditionally; done is high only in DONE.
- start is ignored when not in IDLE. Accepting start clears res_cnt, both error flags and the feed counter t.
- ld_en is honoured only in IDLE and ignored otherwise. The write lands in the memory the following cycle; ld_en and start in the same cycle are both honoured.
- Feed, with t = 0..FEED_LEN-1 counted from the first FEED cycle:
  - Lane i drives beat k = t-i when 0 <= t-i < K_LEN, with its valid bit high.
  - Otherwise the lane drives data 0 and valid low.
  - Outputs are registered: beat 0 of lane 0 appears on the cycle after FEED entry.
  - The A and B buffers use the same skew.
- Capture, active in FEED and DRAIN:
  - On each lane j with valid_s_in[j] high, write s_in_bus[j] to res[j][res_cnt[j]] and increment res_cnt[j].
  - A valid arriving when res_cnt[j]==K_LEN is dropped and sets err_ovf; the count saturates.
  - Valids are ignored in IDLE and DONE.
- Reset mid-run: immediate return to IDLE; valid outputs drop asynchronously; partial results stay readable but res_cnt reads 0.
- No arithmetic is done on operands; result width is passed through unchanged.

Optional Feature:
DENSE_MULT_SEQ_PERF_EN
- Defined: cycle_cnt counts cycles from FEED entry to DONE inclusive, saturating at 16'hFFFF. It holds its value until the next accepted start.
- Not defined: cycle_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package dense_mult_pkg:
  - lane/index width helper constants;
  - state enum type (IDLE/FEED/DRAIN/DONE);
  - typedefs for the operand word and result word.
- Sub-module lane_skew_rd: a per-lane operand buffer with skewed read-address generation and valid generation, instanced 2*LANES times. The FSM and capture logic stay in the top.

Test Plan:
- Load A lane i beat k = 8*i+k and B = 0x40+8*i+k, then pulse start. Expect lane 2 beat 0 (A=0x10) valid 3 cycles after FEED entry, lane 4 last beat on feed cycle 11, busy high for FEED_LEN=12 cycles plus drain.
- A model array returns K_LEN valids per lane. Expect done pulse once, res_cnt all 8, err flags 0, and rd_data matching captured values one cycle after rd_lane/rd_idx.
- Model withholds lane 3 results. Expect DONE after 24 drain cycles, err_timeout=1, res_cnt[3]=0; the next start clears err_timeout.
- Model sends 9 valids on lane 0. Expect err_ovf=1, res_cnt[0]=8, res[0][7] not overwritten.
- Pulse start while busy and ld_en mid-FEED. Expect no restart and operand memory unchanged; then assert rst_n low mid-FEED and expect all valid outputs 0, busy 0 and state IDLE immediately.
- With DENSE_MULT_SEQ_PERF_EN, a completed normal run gives cycle_cnt = FEED_LEN + drain cycles + 1. Without the macro, cycle_cnt reads 0.
